// File: rtl/n64_joybus_tx_if.sv
// n64_joybus_tx_if
//   Bundles the command-side request signals and the transmitter status/line
//   signals of the Joybus command transmitter.
//
//   Signals:
//     start     - request to send a frame (master -> slave)
//     num_bytes - frame length, 1..MAX_BYTES (master -> slave)
//     tx_data   - frame bytes, byte i at tx_data[8*(MAX_BYTES-i)-1 -: 8]
//     busy      - frame on the line (slave -> master)
//     data_out  - serial line level, idle high (slave -> master)
//     done      - one-cycle pulse when the stop bit completes
//     err       - one-cycle pulse when a start is rejected
//
//   Handshake: start is a level request that is only looked at while the
//   transmitter is idle (busy=0). A start with a legal length is accepted on
//   that clock edge and busy rises on the next. A start with an illegal length
//   returns an err pulse instead. A start seen while busy is ignored. The
//   transmitter returns to idle with a single done pulse, and a start held
//   high during that done cycle is accepted on the following edge.
interface n64_joybus_tx_if #(
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = 3
);
    logic                   start;
    logic [LEN_W-1:0]       num_bytes;
    logic [8*MAX_BYTES-1:0] tx_data;
    logic                   busy;
    logic                   data_out;
    logic                   done;
    logic                   err;

    modport master (
        output start, num_bytes, tx_data,
        input  busy, data_out, done, err
    );

    modport slave (
        input  start, num_bytes, tx_data,
        output busy, data_out, done, err
    );
endinterface

// File: rtl/n64_joybus_tx.sv
// n64_joybus_tx
//   Serialises a console command frame of 1..MAX_BYTES bytes onto the N64
//   controller data line, MSB first, byte 0 first, then appends the console
//   stop bit. Every bit cell is T_BIT clocks: low for T_LOW, the data value
//   up to T_DATA, then high. The stop bit is T_LOW low followed by high up to
//   T_STOP clocks in total.
//
//   Ports:
//     clk       - system clock
//     reset     - asynchronous active-high reset
//     bus       - n64_joybus_tx_if.slave (start/num_bytes/tx_data in,
//                 busy/data_out/done/err out)
//     dbg_state - current FSM state (0=IDLE, 1=DATA, 2=STOP)
module n64_joybus_tx #(
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = 3,
    parameter int T_LOW     = 100,
    parameter int T_DATA    = 300,
    parameter int T_BIT     = 400,
    parameter int T_STOP    = 200,
    parameter int CNT_W     = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    n64_joybus_tx_if.slave       bus,
    output logic [1:0]           dbg_state
);
    localparam int TOT_BITS = 8 * MAX_BYTES;
    localparam int IDX_W    = (TOT_BITS > 1) ? $clog2(TOT_BITS) : 1;

    localparam logic [CNT_W-1:0] T_LOW_C    = CNT_W'(T_LOW);
    localparam logic [CNT_W-1:0] T_DATA_C   = CNT_W'(T_DATA);
    localparam logic [CNT_W-1:0] T_BIT_END  = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] T_STOP_END = CNT_W'(T_STOP - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_C  = LEN_W'(MAX_BYTES);
    localparam logic [IDX_W-1:0] TOP_IDX    = IDX_W'(TOT_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                state_q, state_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [IDX_W-1:0]      idx_q, idx_n;
    logic [IDX_W-1:0]      last_q, last_n;
    logic [TOT_BITS-1:0]   data_q;
    logic                  load;
    logic                  len_ok;
    logic                  done_n, err_n, line_n;
    logic                  busy_q, line_q, done_q, err_q;

    assign len_ok = (bus.num_bytes != '0) && (bus.num_bytes <= MAX_LEN_C);
    // Index of the final bit of the frame, 8*num_bytes-1.
    assign last_n = IDX_W'({bus.num_bytes, 3'b000} - 1);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        load    = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (len_ok) begin
                        load    = 1'b1;
                        state_n = DATA;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt_q == T_BIT_END) begin
                    cnt_n = '0;
                    if (idx_q == last_q) begin
                        state_n = STOP;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == T_STOP_END) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The line level is registered, so it is derived from the next cell
    // position. On the accepting edge cnt_n is 0, which drives low before
    // data_q is loaded, so the stale shift data is never visible.
    always_comb begin
        line_n = 1'b1;
        case (state_n)
            DATA: begin
                if (cnt_n < T_LOW_C)
                    line_n = 1'b0;
                else if (cnt_n < T_DATA_C)
                    line_n = data_q[TOP_IDX - idx_n];
                else
                    line_n = 1'b1;
            end
            STOP:    line_n = (cnt_n >= T_LOW_C);
            default: line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            if (load) begin
                data_q <= bus.tx_data;
                last_q <= last_n;
            end
            busy_q <= (state_n != IDLE);
            line_q <= line_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.data_out = line_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_n64_joybus_tx.sv
module tb_n64_joybus_tx;
    localparam int MAX_BYTES = 4;
    localparam int LEN_W     = 3;
    localparam int T_LOW     = 100;
    localparam int T_DATA    = 300;
    localparam int T_BIT     = 400;
    localparam int T_STOP    = 200;
    localparam int CNT_W     = 9;
    localparam int DW        = 8 * MAX_BYTES;

    // Scoreboard event encoding: [31:30] kind, [29] line level, [28:0] count.
    localparam logic [1:0] EV_RUN  = 2'd0;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    n64_joybus_tx_if #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) bus ();

    n64_joybus_tx #(
        .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W), .T_LOW(T_LOW), .T_DATA(T_DATA),
        .T_BIT(T_BIT), .T_STOP(T_STOP), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int check_cnt = 0;
    int pass_cnt  = 0;
    int idle_bad  = 0;

    function automatic logic [31:0] mk_ev(input logic [1:0] kind, input logic lvl, input int cnt);
        logic [31:0] c;
        c = cnt;
        return {kind, lvl, c[28:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic emit(input string name, input logic [31:0] act);
        logic [31:0] e;
        check_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: got %0h with nothing expected", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act === e) pass_cnt++;
            else $display("FAIL %s: got %0h expected %0h", name, act, e);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is described as the sequence of constant-level runs the line
    // shows while busy, followed by the done event carrying the busy length.
    task automatic model_frame(input int n, input logic [DW-1:0] data);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = data[8*(MAX_BYTES-i)-1 -: 8];
            for (int k = 7; k >= 0; k--) begin
                if (b[k]) begin
                    exp_q.push_back(mk_ev(EV_RUN, 1'b0, T_LOW));
                    exp_q.push_back(mk_ev(EV_RUN, 1'b1, T_BIT - T_LOW));
                end else begin
                    exp_q.push_back(mk_ev(EV_RUN, 1'b0, T_DATA));
                    exp_q.push_back(mk_ev(EV_RUN, 1'b1, T_BIT - T_DATA));
                end
            end
        end
        exp_q.push_back(mk_ev(EV_RUN, 1'b0, T_LOW));
        exp_q.push_back(mk_ev(EV_RUN, 1'b1, T_STOP - T_LOW));
        exp_q.push_back(mk_ev(EV_DONE, 1'b0, 8 * n * T_BIT + T_STOP));
    endtask

    task automatic model_request(input int n, input logic [DW-1:0] data);
        if (n >= 1 && n <= MAX_BYTES) model_frame(n, data);
        else exp_q.push_back(mk_ev(EV_ERR, 1'b0, 0));
    endtask

    // ---------------- monitor ----------------
    logic in_frame = 1'b0;
    logic cur_lvl  = 1'b1;
    int   run_len  = 0;
    int   busy_len = 0;

    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (bus.busy) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cur_lvl  = bus.data_out;
                    run_len  = 1;
                    busy_len = 1;
                end else begin
                    busy_len++;
                    if (bus.data_out == cur_lvl) run_len++;
                    else begin
                        emit("line_run", mk_ev(EV_RUN, cur_lvl, run_len));
                        cur_lvl = bus.data_out;
                        run_len = 1;
                    end
                end
            end else begin
                if (in_frame) begin
                    emit("line_run", mk_ev(EV_RUN, cur_lvl, run_len));
                    in_frame = 1'b0;
                end
                if (!bus.data_out) idle_bad++;
            end
            if (bus.done) begin
                check("done_busy_excl", {31'd0, bus.busy}, 32'd0);
                check("done_err_excl", {31'd0, bus.err}, 32'd0);
                emit("frame_done", mk_ev(EV_DONE, 1'b0, busy_len));
            end
            if (bus.err) emit("start_err", mk_ev(EV_ERR, 1'b0, 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic request(input int n, input logic [DW-1:0] data);
        logic [LEN_W-1:0] len;
        len = LEN_W'(n);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_bytes = len;
        bus.tx_data   = data;
        model_request(n, data);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_cnt++;
            $display("FAIL %s: done not seen within 20000 cycles", name);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d;
        int n;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.num_bytes = '0;
        bus.tx_data   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_line", {31'd0, bus.data_out}, 32'd1);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_err", {31'd0, bus.err}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Status command 0x00 and poll command 0x01.
        request(1, 32'h0000_0000);
        wait_done("status");
        request(1, 32'h0100_0000);
        wait_done("poll");

        // Three-byte frame with inputs scrambled mid-frame.
        request(3, 32'h0380_01AA);
        repeat (2000) @(negedge clk);
        bus.tx_data   = $urandom;
        bus.num_bytes = LEN_W'($urandom_range(0, 7));
        wait_done("multi");
        repeat (2) @(negedge clk);

        // Illegal lengths.
        request(0, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        request(5, 32'h1234_5678);
        repeat (3) @(negedge clk);
        request(7, 32'h1234_5678);
        repeat (3) @(negedge clk);

        // Mid-frame start ignored, then start held through done.
        request(1, 32'hA5FF_FFFF);
        repeat (1000) @(negedge clk);
        bus.start     = 1'b1;
        bus.num_bytes = 3'd0;
        @(negedge clk);
        bus.num_bytes = 3'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (1500) @(negedge clk);
        d = $urandom;
        bus.start     = 1'b1;
        bus.num_bytes = 3'd1;
        bus.tx_data   = d;
        model_frame(1, d);
        wait_done("b2b_first");
        @(negedge clk);
        check("b2b_busy_after_done", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        wait_done("b2b_second");
        repeat (2) @(negedge clk);

        // Reset in the data phase of byte 1, bit 3.
        request(2, 32'h5AC3_0000);
        repeat (11 * T_BIT + 150) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_line", {31'd0, bus.data_out}, 32'd1);
        check("async_reset_busy", {31'd0, bus.busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        request(1, 32'h0100_0000);
        wait_done("after_reset");
        repeat (2) @(negedge clk);

        // Randomised frames, including the full MAX_BYTES length.
        for (int r = 0; r < 3; r++) begin
            n = (r == 0) ? MAX_BYTES : $urandom_range(1, MAX_BYTES);
            d = $urandom;
            request(n, d);
            wait_done("random");
            repeat (2) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("idle_line_high", idle_bad, 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/n64_joybus_tx.md
Name: n64_joybus_tx

Overview:
- Parametrised Joybus command transmitter. It serialises a console-side command frame of 1..MAX_BYTES bytes onto the N64 controller data line, then appends the console stop bit.
- Successor to the single-byte command writer. Adds a variable byte count, parametrised bit timing, an explicit stop bit, busy/done/err handshakes and an asynchronous reset.
- Sits between the controller-polling FSM, which supplies the command and payload, and the open-drain pad driver. The done pulse hands the line to the response reader.

Parameters:
- MAX_BYTES, 4, maximum frame length in bytes (>=1).
- LEN_W, 3, width of num_bytes; must hold MAX_BYTES.
- T_LOW, 100, clocks of the leading low phase of every bit (1 us at 100 MHz).
- T_DATA, 300, clock index at which the data phase ends; the data phase spans T_LOW..T_DATA-1.
- T_BIT, 400, clocks per bit cell (4 us).
- T_STOP, 200, total clocks of the stop bit: T_LOW low, then T_STOP-T_LOW high.
- CNT_W, 9, width of the cell counter; must hold T_BIT-1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, request to send a frame; sampled only while idle.
- num_bytes, input, LEN_W, frame length; sampled with start.
- tx_data, input, 8*MAX_BYTES, frame bytes. Byte i is tx_data[8*(MAX_BYTES-i)-1 -: 8]. Byte 0 is the command.
- busy, output, 1, high while a frame is on the line.
- data_out, output, 1, serial line level, idle high.
- done, output, 1, one-cycle pulse when the stop bit completes.
- err, output, 1, one-cycle pulse when a start is rejected.

Behaviour:
- Reset: while reset is high, and asynchronously on assertion, busy=0, data_out=1, done=0, err=0, state=IDLE, counters=0. Reset mid-frame aborts the frame immediately; no done pulse is generated.
- States: IDLE, DATA, STOP. All outputs are registered.
- IDLE:
  - data_out=1.
  - start=1 with 1<=num_bytes<=MAX_BYTES at edge k: latch tx_data and num_bytes, bit_idx=0, cnt=0, go to DATA. From edge k+1, busy=1 and data_out=0.
  - start=1 with num_bytes=0 or num_bytes>MAX_BYTES: err=1 for one cycle, stay in IDLE.
- DATA (each bit cell lasts exactly T_BIT cycles):
  - Cell position cnt=0..T_BIT-1.
  - data_out=0 for cnt<T_LOW.
  - data_out=current bit for T_LOW<=cnt<T_DATA.
  - data_out=1 for cnt>=T_DATA.
  - Bits go out MSB first, byte 0 first.
  - At cnt=T_BIT-1: cnt wraps to 0 and bit_idx increments. When bit_idx reaches 8*num_bytes-1, go to STOP.
- STOP:
  - data_out=0 for cnt<T_LOW, then 1 until cnt=T_STOP-1.
  - At cnt=T_STOP-1: go to IDLE. On the next edge busy=0 and done=1 for one cycle.
- Frame length: busy is high for exactly 8*num_bytes*T_BIT + T_STOP cycles.
- Latched data: tx_data and num_bytes are ignored after latching. Changes mid-frame have no effect.
- start while busy: ignored, with no err pulse.
- Back-to-back frames: start held high in the done cycle begins a new frame at the next edge, with no extra idle cycle required.
- Pulse exclusivity: done and err never assert together. busy=0 whenever done=1.

Test Plan:
- Status command, num_bytes=1, tx_data top byte 0x00, defaults:
  - Each of the 8 cells is low 300 cycles, then high 100.
  - Stop bit is low 100 cycles, then high 100.
  - busy is high 3400 cycles, then a single done pulse.
- Poll command, num_bytes=1, byte 0x01:
  - Bits 0..6 are low 300 / high 100.
  - Bit 7 is low 100 / high 300.
  - done arrives 3400 cycles after start.
- Multi-byte frame, num_bytes=3, bytes 0x03,0x80,0x01:
  - Line decodes MSB-first as 0x03 0x80 0x01.
  - busy lasts 9800 cycles.
  - tx_data changed mid-frame does not alter the output.
- Invalid length:
  - num_bytes=0 -> err for one cycle; busy stays 0; data_out stays 1.
  - num_bytes=5 -> same response.
- start pulsed during the frame, and again held high through the done cycle:
  - The mid-frame start is ignored, with no err.
  - The second frame starts at the edge after done.
- Reset asserted at byte 1, bit 3, during the data phase:
  - Without waiting for a clock edge, data_out=1 and busy=0.
  - No done pulse.
  - A new start after release transmits correctly.
